ika87ad_extbus_bridge: RTL and testbench

//  Sits between the IKA87AD external bus (o_A/o_RD_n/o_WR_n/o_DO/i_DI) and a slow, handshaked memory

---
 rtl/ika87ad_pkg.sv | 14 +
 rtl/ika87ad_bus_timer.sv | 28 ++
 rtl/ika87ad_extbus_bridge.sv | 137 +++++++++++++
 tb/tb_ika87ad_extbus_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ika87ad_pkg.sv
// Shared types and defaults for the IKA87AD external-bus to memory-port bridge.
package ika87ad_pkg;

    typedef enum logic [1:0] {
        BR_IDLE,
        BR_RD_WAIT,
        BR_WR_WAIT,
        BR_DONE
    } br_state_t;

    localparam int unsigned DW               = 8;
    localparam logic [7:0]  OPEN_BUS_DEFAULT = 8'hFF;

endpackage

// File: rtl/ika87ad_bus_timer.sv
// Outstanding-request timer: cleared on a new transaction, counts while enabled, holds at terminal count.
module ika87ad_bus_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic emuclk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] cnt;

    assign tc_c = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge emuclk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc_c) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ika87ad_extbus_bridge.sv
// Converts IKA87AD RD_n/WR_n strobes into req/ack memory transactions, stalling the core via PCEN gating.
module ika87ad_extbus_bridge
    import ika87ad_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [7:0]  OPEN_BUS = OPEN_BUS_DEFAULT
) (
    input  logic          i_EMUCLK,
    input  logic          i_RESET,
    input  logic          i_PCEN_RAW,
    output logic          o_MCUCLK_PCEN,
    input  logic [15:0]   i_A,
    input  logic          i_RD_n,
    input  logic          i_WR_n,
    input  logic [DW-1:0] i_DO,
    output logic [DW-1:0] o_DI,
    output logic [AW-1:0] o_MEM_ADDR,
    output logic          o_MEM_RD,
    output logic          o_MEM_WR,
    output logic [DW-1:0] o_MEM_WDATA,
    input  logic          i_MEM_ACK,
    input  logic [DW-1:0] i_MEM_RDATA,
    output logic          o_TIMEOUT,
    output logic          o_PROTO_ERR
);

    br_state_t     state, state_d;
    logic          rd_q, wr_q;
    logic          rd_fall_c, wr_fall_c, start_c, idle_c, wait_c, tc_c;
    logic          mem_rd_d, mem_wr_d, timeout_d, proto_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d, di_d;

    assign idle_c    = (state == BR_IDLE);
    assign wait_c    = (state == BR_RD_WAIT) || (state == BR_WR_WAIT);
    assign rd_fall_c = rd_q & ~i_RD_n;
    assign wr_fall_c = wr_q & ~i_WR_n;
    assign start_c   = (rd_fall_c ^ wr_fall_c) & idle_c;

    // The enable pulse coinciding with a start is swallowed so the core never sees a partial access.
    assign o_MCUCLK_PCEN = i_PCEN_RAW & ~start_c & idle_c & ~i_RESET;

    ika87ad_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .emuclk (i_EMUCLK),
        .reset  (i_RESET),
        .clr    (start_c),
        .en     (wait_c),
        .tc_c   (tc_c)
    );

    // Next-state and registered-output values.
    always_comb begin
        state_d   = state;
        mem_rd_d  = o_MEM_RD;
        mem_wr_d  = o_MEM_WR;
        addr_d    = o_MEM_ADDR;
        wdata_d   = o_MEM_WDATA;
        di_d      = o_DI;
        timeout_d = 1'b0;
        proto_d   = 1'b0;

        case (state)
            BR_IDLE: begin
                proto_d = rd_fall_c & wr_fall_c;
                if (start_c) begin
                    addr_d = AW'(i_A);
                    if (rd_fall_c) begin
                        state_d  = BR_RD_WAIT;
                        mem_rd_d = 1'b1;
                    end else begin
                        state_d  = BR_WR_WAIT;
                        wdata_d  = i_DO;
                        mem_wr_d = 1'b1;
                    end
                end
            end
            BR_RD_WAIT: begin
                if (i_MEM_ACK) begin
                    state_d  = BR_DONE;
                    mem_rd_d = 1'b0;
                    di_d     = i_MEM_RDATA;
                end else if (tc_c) begin
                    state_d   = BR_DONE;
                    mem_rd_d  = 1'b0;
                    di_d      = OPEN_BUS;
                    timeout_d = 1'b1;
                end
            end
            BR_WR_WAIT: begin
                if (i_MEM_ACK) begin
                    state_d  = BR_DONE;
                    mem_wr_d = 1'b0;
                end else if (tc_c) begin
                    state_d   = BR_DONE;
                    mem_wr_d  = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            BR_DONE: begin
                state_d = BR_IDLE;
            end
            default: begin
                state_d = BR_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_RESET) begin
            state       <= BR_IDLE;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            o_MEM_RD    <= 1'b0;
            o_MEM_WR    <= 1'b0;
            o_MEM_ADDR  <= '0;
            o_MEM_WDATA <= '0;
            o_DI        <= OPEN_BUS;
            o_TIMEOUT   <= 1'b0;
            o_PROTO_ERR <= 1'b0;
        end else begin
            state       <= state_d;
            rd_q        <= i_RD_n;
            wr_q        <= i_WR_n;
            o_MEM_RD    <= mem_rd_d;
            o_MEM_WR    <= mem_wr_d;
            o_MEM_ADDR  <= addr_d;
            o_MEM_WDATA <= wdata_d;
            o_DI        <= di_d;
            o_TIMEOUT   <= timeout_d;
            o_PROTO_ERR <= proto_d;
        end
    end

endmodule

// File: tb/tb_ika87ad_extbus_bridge.sv
// Directed self-checking bench for the IKA87AD external-bus bridge (TIMEOUT=8).
module tb_ika87ad_extbus_bridge;

    localparam int NO_ACK = 99;

    logic        clk = 1'b0;
    logic        i_RESET, i_PCEN_RAW, o_MCUCLK_PCEN;
    logic [15:0] i_A;
    logic        i_RD_n, i_WR_n;
    logic [7:0]  i_DO, o_DI;
    logic [15:0] o_MEM_ADDR;
    logic        o_MEM_RD, o_MEM_WR;
    logic [7:0]  o_MEM_WDATA;
    logic        i_MEM_ACK;
    logic [7:0]  i_MEM_RDATA;
    logic        o_TIMEOUT, o_PROTO_ERR;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ika87ad_extbus_bridge #(
        .AW       (16),
        .TIMEOUT  (8),
        .OPEN_BUS (8'hFF)
    ) dut (
        .i_EMUCLK      (clk),
        .i_RESET       (i_RESET),
        .i_PCEN_RAW    (i_PCEN_RAW),
        .o_MCUCLK_PCEN (o_MCUCLK_PCEN),
        .i_A           (i_A),
        .i_RD_n        (i_RD_n),
        .i_WR_n        (i_WR_n),
        .i_DO          (i_DO),
        .o_DI          (o_DI),
        .o_MEM_ADDR    (o_MEM_ADDR),
        .o_MEM_RD      (o_MEM_RD),
        .o_MEM_WR      (o_MEM_WR),
        .o_MEM_WDATA   (o_MEM_WDATA),
        .i_MEM_ACK     (i_MEM_ACK),
        .i_MEM_RDATA   (i_MEM_RDATA),
        .o_TIMEOUT     (o_TIMEOUT),
        .o_PROTO_ERR   (o_PROTO_ERR)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the strobe-fall cycle; ack_at indexes the cycle carrying i_MEM_ACK.
    task automatic run_txn(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                           input int ack_at, input logic [7:0] rdata, input int ncyc, input int gap,
                           output int gated, output int req_cyc, output int tmo,
                           output logic [15:0] addr_seen, output logic [7:0] wdata_seen,
                           output logic [7:0] di_at_ack, output logic [7:0] di_end);
        gated = 0; req_cyc = 0; tmo = 0;
        addr_seen = '0; wdata_seen = '0; di_at_ack = '0;
        i_A = a;
        i_DO = d;
        if (is_wr) i_WR_n = 1'b0;
        else       i_RD_n = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            i_MEM_ACK   = (c == ack_at);
            i_MEM_RDATA = (c == ack_at) ? rdata : 8'hEE;
            @(negedge clk);
            if (!o_MCUCLK_PCEN) gated++;
            if (o_MEM_RD || o_MEM_WR) begin
                if (req_cyc == 0) begin
                    addr_seen  = o_MEM_ADDR;
                    wdata_seen = o_MEM_WDATA;
                end
                req_cyc++;
            end
            if (o_TIMEOUT) tmo++;
            if (c == ack_at) di_at_ack = o_DI;
            next_cycle();
        end
        i_MEM_ACK   = 1'b0;
        i_MEM_RDATA = 8'h00;
        i_RD_n      = 1'b1;
        i_WR_n      = 1'b1;
        di_end      = o_DI;
        for (int g = 0; g < gap; g++) next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int          gated, req_cyc, tmo;
        logic [15:0] addr_seen;
        logic [7:0]  wdata_seen, di_at_ack, di_end;

        i_RESET = 1'b1; i_PCEN_RAW = 1'b1; i_A = '0; i_RD_n = 1'b1; i_WR_n = 1'b1;
        i_DO = '0; i_MEM_ACK = 1'b0; i_MEM_RDATA = '0;
        repeat (3) next_cycle();

        // Reset state
        @(negedge clk);
        check_eq("rst_pcen", 32'(o_MCUCLK_PCEN), 32'd0);
        check_eq("rst_di",   32'(o_DI), 32'hFF);
        check_eq("rst_req",  32'({o_MEM_RD, o_MEM_WR}), 32'd0);
        check_eq("rst_addr", 32'(o_MEM_ADDR), 32'd0);
        check_eq("rst_flags", 32'({o_TIMEOUT, o_PROTO_ERR}), 32'd0);
        next_cycle();
        i_RESET = 1'b0;
        @(negedge clk);
        check_eq("idle_pcen", 32'(o_MCUCLK_PCEN), 32'd1);
        next_cycle();

        // Zero-wait read
        run_txn(1'b0, 16'h0123, 8'h00, 1, 8'h5A, 6, 1,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("zw_gated", 32'(gated), 32'd3);
        check_eq("zw_req",   32'(req_cyc), 32'd1);
        check_eq("zw_addr",  32'(addr_seen), 32'h0123);
        check_eq("zw_di",    32'(di_end), 32'h5A);

        // Wait-state read: ack on the 5th WAIT cycle
        run_txn(1'b0, 16'h2040, 8'h00, 5, 8'hA5, 10, 1,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("ws_gated",   32'(gated), 32'd7);
        check_eq("ws_req",     32'(req_cyc), 32'd5);
        check_eq("ws_di_old",  32'(di_at_ack), 32'h5A);
        check_eq("ws_di_new",  32'(di_end), 32'hA5);
        check_eq("ws_tmo",     32'(tmo), 32'd0);

        // Write
        run_txn(1'b1, 16'hFF10, 8'hC3, 3, 8'h11, 8, 1,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("wr_addr",  32'(addr_seen), 32'hFF10);
        check_eq("wr_wdata", 32'(wdata_seen), 32'hC3);
        check_eq("wr_req",   32'(req_cyc), 32'd3);
        check_eq("wr_gated", 32'(gated), 32'd5);
        check_eq("wr_di",    32'(di_end), 32'hA5);

        // Read timeout
        run_txn(1'b0, 16'h0777, 8'h00, NO_ACK, 8'h00, 14, 1,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("to_req",   32'(req_cyc), 32'd8);
        check_eq("to_pulse", 32'(tmo), 32'd1);
        check_eq("to_gated", 32'(gated), 32'd10);
        check_eq("to_di",    32'(di_end), 32'hFF);

        // Next read after timeout
        run_txn(1'b0, 16'h0778, 8'h00, 1, 8'h3C, 6, 1,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("post_to_di",    32'(di_end), 32'h3C);
        check_eq("post_to_gated", 32'(gated), 32'd3);

        // Ack on the terminal-count cycle wins
        run_txn(1'b0, 16'h1234, 8'h00, 8, 8'h96, 14, 1,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("acktc_tmo", 32'(tmo), 32'd0);
        check_eq("acktc_di",  32'(di_end), 32'h96);
        check_eq("acktc_req", 32'(req_cyc), 32'd8);

        // Reset two cycles into RD_WAIT, then a spurious ack
        i_A = 16'h4444;
        i_RD_n = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rmid_req_pre", 32'(o_MEM_RD), 32'd1);
        i_RESET = 1'b1;
        i_RD_n  = 1'b1;
        @(negedge clk);
        check_eq("rmid_pcen", 32'(o_MCUCLK_PCEN), 32'd0);
        next_cycle();
        i_RESET = 1'b0;
        @(negedge clk);
        check_eq("rmid_req", 32'(o_MEM_RD), 32'd0);
        check_eq("rmid_di",  32'(o_DI), 32'hFF);
        check_eq("rmid_idle", 32'(o_MCUCLK_PCEN), 32'd1);
        next_cycle();
        i_MEM_ACK = 1'b1;
        i_MEM_RDATA = 8'h77;
        next_cycle();
        i_MEM_ACK = 1'b0;
        @(negedge clk);
        check_eq("spur_di",  32'(o_DI), 32'hFF);
        check_eq("spur_req", 32'({o_MEM_RD, o_MEM_WR}), 32'd0);
        next_cycle();

        // Both strobes fall together
        i_RD_n = 1'b0;
        i_WR_n = 1'b0;
        @(negedge clk);
        check_eq("pe_pcen", 32'(o_MCUCLK_PCEN), 32'd1);
        next_cycle();
        @(negedge clk);
        check_eq("pe_pulse", 32'(o_PROTO_ERR), 32'd1);
        check_eq("pe_req",   32'({o_MEM_RD, o_MEM_WR}), 32'd0);
        i_RD_n = 1'b1;
        i_WR_n = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("pe_clear", 32'(o_PROTO_ERR), 32'd0);
        next_cycle();

        // Back-to-back: WR_n falls on the same cycle RD_n rises
        run_txn(1'b0, 16'h0A0A, 8'h00, 2, 8'h42, 5, 0,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("b2b_rd_di",  32'(di_end), 32'h42);
        check_eq("b2b_rd_req", 32'(req_cyc), 32'd2);
        run_txn(1'b1, 16'h0B0B, 8'h5E, 1, 8'h00, 5, 1,
                gated, req_cyc, tmo, addr_seen, wdata_seen, di_at_ack, di_end);
        check_eq("b2b_wr_req",   32'(req_cyc), 32'd1);
        check_eq("b2b_wr_addr",  32'(addr_seen), 32'h0B0B);
        check_eq("b2b_wr_wdata", 32'(wdata_seen), 32'h5E);
        check_eq("b2b_wr_di",    32'(di_end), 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
